nibble_serial_addsub: RTL

- Multi-cycle 32-bit add/subtract unit for the ARITH path of the ALU.
- Reuses one 4-bit carry-skip slice, processing one nibble per clock, least-significant nibble first.
- Sits upstream of the slice: sequences operands into it, chains the carry between nibbles, and assembles the result and flags for the ALU result mux.
- Trades latency for area against the parallel 32-bit adder.

---
 rtl/nibble_serial_addsub_pkg.sv | 21 ++
 rtl/fourbit_carry_skip_block.sv | 29 ++
 rtl/nibble_serial_addsub.sv | 128 ++++++++++++
 3 files changed

// File: rtl/nibble_serial_addsub_pkg.sv
// Shared ARITH definitions: FSM state encoding, slice width and the flag
// bundle common to the serial and parallel adders.
package nibble_serial_addsub_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } arith_state_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } arith_flags_t;

  localparam arith_flags_t FLAGS_RST = '{cout: 1'b0, ovf: 1'b0, zero: 1'b1};

endpackage

// File: rtl/fourbit_carry_skip_block.sv
// 4-bit carry-skip adder slice.
//   a, b : nibble operands
//   c0   : carry in
//   s    : nibble sum
//   cp   : carry out; bypasses the ripple chain when every bit propagates
module fourbit_carry_skip_block (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       cp
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p    = a ^ b;
  assign g    = a & b;
  assign c[0] = c0;

  for (genvar i = 0; i < 4; i++) begin : g_rip
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign s  = p ^ c[3:0];
  assign cp = (&p) ? c0 : c[4];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial add/subtract: one shared 4-bit slice, LS nibble first,
// NIBS clocks per operation plus one DONE cycle.
//   clk, rst_n   : clock, async active-low reset
//   start/sub/a/b: request, sampled when ready=1
//   ready/busy   : accept window / operation in progress
//   done         : one-cycle pulse, result and flags valid from here
//   result       : sum/difference (partial nibbles visible during RUN)
//   cout/ovf/zero: flags, updated on entry to DONE and held otherwise
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  if (WIDTH % NIB_W != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of 4");
  end

  arith_state_e     state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, result_q, res_nxt;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  arith_flags_t     flags_q, flags_nxt;
  logic [NIB_W-1:0] sl_a, sl_b, sl_s;
  logic             sl_cp;
  logic             accept, last;

  assign accept = start & ready;
  assign last   = (cnt_q == CNT_W'(NIBS - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state; DONE accepts a new start just like IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready = 1'b1;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_RUN:   begin ready = 1'b0; busy = 1'b1; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Slice operands for the current nibble; b_q already holds ~b for sub.
  assign sl_a = a_q[int'(cnt_q)*NIB_W +: NIB_W];
  assign sl_b = b_q[int'(cnt_q)*NIB_W +: NIB_W];

  fourbit_carry_skip_block u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .c0 (carry_q),
    .s  (sl_s),
    .cp (sl_cp)
  );

  always_comb begin
    res_nxt = result_q;
    res_nxt[int'(cnt_q)*NIB_W +: NIB_W] = sl_s;
  end

  // Flags are computed from the fully assembled result on the last nibble.
  always_comb begin
    flags_nxt.cout = sl_cp;
    flags_nxt.ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                     (res_nxt[WIDTH-1] != a_q[WIDTH-1]);
    flags_nxt.zero = (res_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= FLAGS_RST;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub;              // +1 of the two's-complement negate
      cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      result_q <= res_nxt;
      carry_q  <= sl_cp;
      if (last) flags_q <= flags_nxt;
      else      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign result = result_q;
  assign cout   = flags_q.cout;
  assign ovf    = flags_q.ovf;
  assign zero   = flags_q.zero;

endmodule
